axi4_lite_master: RTL

AXI4_LITE_MASTER -- requirements
Module: axi4_lite_master

---
 rtl/axi4_lite_master.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/axi4_lite_master.sv
// AXI4-Lite master: each accepted command becomes one AXI transaction and one response.
// Define AXI4_LITE_MASTER_TIMEOUT_EN to build in the sticky per-state watchdog.

module axi4_lite_master #(
   parameter int unsigned ADDRESS        = 32,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic                  ACLK,
   input  logic                  ARESETN,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDRESS-1:0]    cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   input  logic [3:0]            cmd_wstrb,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic [1:0]            rsp_resp,
   output logic                  timeout_err,
   output logic [ADDRESS-1:0]    M_AWADDR,
   output logic                  M_AWVALID,
   input  logic                  M_AWREADY,
   output logic [DATA_WIDTH-1:0] M_WDATA,
   output logic [3:0]            M_WSTRB,
   output logic                  M_WVALID,
   input  logic                  M_WREADY,
   input  logic                  M_BVALID,
   output logic                  M_BREADY,
   input  logic [1:0]            M_BRESP,
   output logic [ADDRESS-1:0]    M_ARADDR,
   output logic                  M_ARVALID,
   input  logic                  M_ARREADY,
   input  logic                  M_RVALID,
   output logic                  M_RREADY,
   input  logic [DATA_WIDTH-1:0] M_RDATA,
   input  logic [1:0]            M_RRESP
);

   typedef enum logic [2:0] {StIdle, StWrite, StWresp, StRaddr, StRdata, StRsp} state_t;

   state_t                r_state;
   logic                  r_cmd_ready;
   logic [ADDRESS-1:0]    r_awaddr;
   logic [ADDRESS-1:0]    r_araddr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [3:0]            r_wstrb;
   logic                  r_awvalid;
   logic                  r_wvalid;
   logic                  r_bready;
   logic                  r_arvalid;
   logic                  r_rready;
   logic                  r_rsp_valid;
   logic [DATA_WIDTH-1:0] r_rsp_rdata;
   logic [1:0]            r_rsp_resp;
   logic                  w_aw_done;
   logic                  w_w_done;

   // A channel counts as done if its handshake happened earlier or happens on this edge.
   assign w_aw_done = !r_awvalid || M_AWREADY;
   assign w_w_done  = !r_wvalid || M_WREADY;

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_state     <= StIdle;
         r_cmd_ready <= 1'b0;
         r_awaddr    <= '0;
         r_araddr    <= '0;
         r_wdata     <= '0;
         r_wstrb     <= '0;
         r_awvalid   <= 1'b0;
         r_wvalid    <= 1'b0;
         r_bready    <= 1'b0;
         r_arvalid   <= 1'b0;
         r_rready    <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_resp  <= '0;
      end else begin
         unique case (r_state)
            StIdle: begin
               r_cmd_ready <= 1'b1;
               if (cmd_valid && r_cmd_ready) begin
                  r_cmd_ready <= 1'b0;
                  if (cmd_write) begin
                     r_state   <= StWrite;
                     r_awaddr  <= cmd_addr;
                     r_wdata   <= cmd_wdata;
                     r_wstrb   <= cmd_wstrb;
                     r_awvalid <= 1'b1;
                     r_wvalid  <= 1'b1;
                  end else begin
                     r_state   <= StRaddr;
                     r_araddr  <= cmd_addr;
                     r_arvalid <= 1'b1;
                  end
               end
            end
            StWrite: begin
               if (r_awvalid && M_AWREADY) r_awvalid <= 1'b0;
               if (r_wvalid && M_WREADY)   r_wvalid  <= 1'b0;
               if (w_aw_done && w_w_done) begin
                  r_state  <= StWresp;
                  r_bready <= 1'b1;
               end
            end
            StWresp: begin
               if (M_BVALID) begin
                  r_bready    <= 1'b0;
                  r_rsp_resp  <= M_BRESP;
                  r_rsp_rdata <= '0;
                  r_rsp_valid <= 1'b1;
                  r_state     <= StRsp;
               end
            end
            StRaddr: begin
               if (M_ARREADY) begin
                  r_arvalid <= 1'b0;
                  r_rready  <= 1'b1;
                  r_state   <= StRdata;
               end
            end
            StRdata: begin
               if (M_RVALID) begin
                  r_rready    <= 1'b0;
                  r_rsp_rdata <= M_RDATA;
                  r_rsp_resp  <= M_RRESP;
                  r_rsp_valid <= 1'b1;
                  r_state     <= StRsp;
               end
            end
            StRsp: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_cmd_ready <= 1'b1;
                  r_state     <= StIdle;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES);

   state_t          r_wd_prev;
   logic [CntW-1:0] r_wd_cnt;
   logic            r_timeout;
   logic            w_busy;

   assign w_busy = (r_state == StWrite) || (r_state == StWresp) ||
                   (r_state == StRaddr) || (r_state == StRdata);

   // r_wd_cnt holds the number of cycles already spent in the current state.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_wd_prev <= StIdle;
         r_wd_cnt  <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_wd_prev <= r_state;
         if (!w_busy) begin
            r_wd_cnt <= '0;
         end else if (r_state != r_wd_prev) begin
            r_wd_cnt <= CntW'(1);
         end else if (r_wd_cnt != CntMax) begin
            r_wd_cnt <= CntW'(r_wd_cnt + 1'b1);
            if (CntW'(r_wd_cnt + 1'b1) == CntMax) r_timeout <= 1'b1;
         end
      end
   end

   assign timeout_err = r_timeout;
`else
   assign timeout_err = 1'b0;
`endif

   assign cmd_ready = r_cmd_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_resp  = r_rsp_resp;
   assign M_AWADDR  = r_awaddr;
   assign M_AWVALID = r_awvalid;
   assign M_WDATA   = r_wdata;
   assign M_WSTRB   = r_wstrb;
   assign M_WVALID  = r_wvalid;
   assign M_BREADY  = r_bready;
   assign M_ARADDR  = r_araddr;
   assign M_ARVALID = r_arvalid;
   assign M_RREADY  = r_rready;

endmodule
